// File: rtl/sequenced_arith_pe_if.sv
// Signal bundle between sequenced_arith_pe and its surroundings: instruction config,
// program control, operand request/response and result valid/ready handshake.
interface sequenced_arith_pe_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_NUM        = 8,
  parameter int INSTRUCTION_NUM = 16
);
  localparam int DW_IDX = $clog2(DATA_NUM);
  localparam int IW_IDX = $clog2(INSTRUCTION_NUM);

  logic                  configure;
  logic [3:0]            operationConf;
  logic [DW_IDX-1:0]     dataIn0Conf;
  logic [DW_IDX-1:0]     dataIn1Conf;
  logic [DW_IDX-1:0]     dataOutConf;
  logic [IW_IDX-1:0]     instructionNumberConf;
  logic                  configError;
  logic                  start;
  logic [IW_IDX:0]       programLength;
  logic                  loopEnable;
  logic                  dataInRequestValid;
  logic [DW_IDX-1:0]     dataIn0Request;
  logic [DW_IDX-1:0]     dataIn1Request;
  logic                  dataInValid;
  logic [DATA_WIDTH-1:0] dataIn0;
  logic [DATA_WIDTH-1:0] dataIn1;
  logic                  dataOutValid;
  logic                  dataOutReady;
  logic [DATA_WIDTH-1:0] dataOut;
  logic [DW_IDX-1:0]     dataOutDestination;
  logic [IW_IDX-1:0]     instructionNumber;
  logic                  busy;
  logic                  done;

  // The processing element side.
  modport master (
    input  configure, operationConf, dataIn0Conf, dataIn1Conf, dataOutConf,
           instructionNumberConf, start, programLength, loopEnable,
           dataInValid, dataIn0, dataIn1, dataOutReady,
    output configError, dataInRequestValid, dataIn0Request, dataIn1Request,
           dataOutValid, dataOut, dataOutDestination, instructionNumber, busy, done
  );

  // The fabric / config loader side.
  modport slave (
    output configure, operationConf, dataIn0Conf, dataIn1Conf, dataOutConf,
           instructionNumberConf, start, programLength, loopEnable,
           dataInValid, dataIn0, dataIn1, dataOutReady,
    input  configError, dataInRequestValid, dataIn0Request, dataIn1Request,
           dataOutValid, dataOut, dataOutDestination, instructionNumber, busy, done
  );
endinterface

// File: rtl/sequenced_arith_pe.sv
// Programmable arithmetic PE: instruction store written via config port, then an FSM
// fetches each slot, requests operands, executes one ALU op and hands off a tagged result.
module sequenced_arith_pe #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_NUM        = 8,
  parameter int INSTRUCTION_NUM = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sequenced_arith_pe_if.master bus
);
  localparam int DW_IDX = $clog2(DATA_NUM);
  localparam int IW_IDX = $clog2(INSTRUCTION_NUM);
  localparam int SH_W   = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_W  = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_W   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IW_IDX:0]       MAX_LEN = (IW_IDX+1)'(INSTRUCTION_NUM);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_REQUEST   = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [3:0]            op_mem_r   [INSTRUCTION_NUM];
  logic [DW_IDX-1:0]     src0_mem_r [INSTRUCTION_NUM];
  logic [DW_IDX-1:0]     src1_mem_r [INSTRUCTION_NUM];
  logic [DW_IDX-1:0]     dst_mem_r  [INSTRUCTION_NUM];
  logic                  cfg_err_r;
  logic [IW_IDX-1:0]     pc_r;
  logic [IW_IDX:0]       len_r;
  logic                  loop_r;
  logic [3:0]            op_r;
  logic [DW_IDX-1:0]     src0_r, src1_r, dst_r, dest_r;
  logic [DATA_WIDTH-1:0] a_r, b_r, dout_r;
  logic                  req_valid_r, out_valid_r, busy_r, done_r;
  logic                  req_valid_nxt_s, out_valid_nxt_s, busy_nxt_s, done_nxt_s;
  logic                  idle_or_done_s, start_ok_s, handshake_s, last_s;
  logic [IW_IDX:0]       pc_inc_s, len_clamp_s;

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [3:0] op,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic [SH_W-1:0]       sh;
    logic [DATA_WIDTH-1:0] r;
    sh = b[SH_W-1:0];
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = $unsigned($signed(a) >>> sh);
      4'd8:    r = a * b;
      4'd9:    r = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      4'd10:   r = (a < b) ? ONE_W : ZERO_W;
      4'd11:   r = a;
      4'd12:   r = ($signed(a) < $signed(b)) ? a : b;
      4'd13:   r = ($signed(a) < $signed(b)) ? b : a;
      default: r = ZERO_W;
    endcase
    return r;
  endfunction

  assign idle_or_done_s = (state_r == S_IDLE) || (state_r == S_DONE);
  assign start_ok_s     = bus.start && idle_or_done_s;
  assign handshake_s    = (state_r == S_WRITEBACK) && bus.dataOutReady;
  assign pc_inc_s       = {1'b0, pc_r} + {{IW_IDX{1'b0}}, 1'b1};
  assign last_s         = (pc_inc_s == len_r);

  // Clamp the requested program length to the store size.
  always_comb begin
    len_clamp_s = bus.programLength;
    if (bus.programLength > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = bus.programLength;
    end
  end

  // Instruction store and config-drop flag; writes are only accepted while not running.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < INSTRUCTION_NUM; i++) begin
        op_mem_r[i]   <= 4'd0;
        src0_mem_r[i] <= {DW_IDX{1'b0}};
        src1_mem_r[i] <= {DW_IDX{1'b0}};
        dst_mem_r[i]  <= {DW_IDX{1'b0}};
      end
      cfg_err_r <= 1'b0;
    end else begin
      if (bus.configure && idle_or_done_s) begin
        op_mem_r[bus.instructionNumberConf]   <= bus.operationConf;
        src0_mem_r[bus.instructionNumberConf] <= bus.dataIn0Conf;
        src1_mem_r[bus.instructionNumberConf] <= bus.dataIn1Conf;
        dst_mem_r[bus.instructionNumberConf]  <= bus.dataOutConf;
      end
      cfg_err_r <= bus.configure && !idle_or_done_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt_s = (len_clamp_s == {(IW_IDX+1){1'b0}}) ? S_DONE : S_FETCH;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_FETCH:   state_nxt_s = S_REQUEST;
      S_REQUEST: begin
        if (bus.dataInValid) begin
          state_nxt_s = S_EXECUTE;
        end else begin
          state_nxt_s = S_REQUEST;
        end
      end
      S_EXECUTE: state_nxt_s = S_WRITEBACK;
      S_WRITEBACK: begin
        if (bus.dataOutReady) begin
          state_nxt_s = (last_s && !loop_r) ? S_DONE : S_FETCH;
        end else begin
          state_nxt_s = S_WRITEBACK;
        end
      end
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the registered copies line up with state_r.
  always_comb begin
    req_valid_nxt_s = (state_nxt_s == S_REQUEST);
    out_valid_nxt_s = (state_nxt_s == S_WRITEBACK);
    done_nxt_s      = (state_nxt_s == S_DONE);
    busy_nxt_s      = (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      req_valid_r <= req_valid_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Datapath: program counter, fetched instruction, operands and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r   <= {IW_IDX{1'b0}};
      len_r  <= {(IW_IDX+1){1'b0}};
      loop_r <= 1'b0;
      op_r   <= 4'd0;
      src0_r <= {DW_IDX{1'b0}};
      src1_r <= {DW_IDX{1'b0}};
      dst_r  <= {DW_IDX{1'b0}};
      dest_r <= {DW_IDX{1'b0}};
      a_r    <= ZERO_W;
      b_r    <= ZERO_W;
      dout_r <= ZERO_W;
    end else begin
      if (start_ok_s) begin
        len_r  <= len_clamp_s;
        loop_r <= bus.loopEnable;
        pc_r   <= {IW_IDX{1'b0}};
      end else if (handshake_s) begin
        // On the final slot pc wraps for looping programs and otherwise holds for DONE.
        if (last_s) begin
          pc_r <= loop_r ? {IW_IDX{1'b0}} : pc_r;
        end else begin
          pc_r <= pc_inc_s[IW_IDX-1:0];
        end
      end
      case (state_r)
        S_FETCH: begin
          op_r   <= op_mem_r[pc_r];
          src0_r <= src0_mem_r[pc_r];
          src1_r <= src1_mem_r[pc_r];
          dst_r  <= dst_mem_r[pc_r];
        end
        S_REQUEST: begin
          if (bus.dataInValid) begin
            a_r <= bus.dataIn0;
            b_r <= bus.dataIn1;
          end
        end
        S_EXECUTE: begin
          dout_r <= alu(op_r, a_r, b_r);
          dest_r <= dst_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.configError        = cfg_err_r;
  assign bus.dataInRequestValid = req_valid_r;
  assign bus.dataIn0Request     = src0_r;
  assign bus.dataIn1Request     = src1_r;
  assign bus.dataOutValid       = out_valid_r;
  assign bus.dataOut            = dout_r;
  assign bus.dataOutDestination = dest_r;
  assign bus.instructionNumber  = pc_r;
  assign bus.busy               = busy_r;
  assign bus.done               = done_r;
endmodule
